lfsr_guess_checker: RTL and testbench
=====================================

Name: lfsr_guess_checker

Overview:
- Consumes the switch-entry stage outputs `sw_in` (player's guess) and `seq_num` (LFSR value currently shown).
- On each submit, computes the true next LFSR state from `seq_num` and compares it with `sw_in`.
- Keeps score, streak and round count, and ends the game after a fixed number of rounds.
- Its outputs drive the LED/7-segment display stage downstream.

Parameters:
- WIDTH, 8, width of LFSR state, `sw_in` and `seq_num`.
- TAPS, 8'hB8, feedback tap mask (x^8+x^6+x^5+x^4+1).
- MAX_ROUNDS, 8, number of scored rounds before the game ends.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- sw_in  input  WIDTH  player's guess of the next LFSR value.
- seq_num  input  WIDTH  current LFSR value presented to the player.
- submit  input  1  level from debounced button; the rising edge triggers a round.
- restart  input  1  synchronous clear of game state; lower priority than reset.
- expected  output  WIDTH  computed next state for the last evaluated round.
- result_valid  output  1  high while in RESULT.
- match  output  1  last round correct; valid when result_valid=1.
- illegal  output  1  last submit had seq_num==0; the round is not counted.
- score  output  8  count of correct rounds, saturating at 255.
- streak  output  8  current consecutive-correct run, saturating at 255.
- rounds  output  8  scored rounds so far.
- game_over  output  1  high in DONE.

Behaviour:
- Clock and reset: one clock `clk`; reset is synchronous and active-high.
  - On reset, all outputs and registers are 0, submit_d=0, state=IDLE.
- Next-state function: next = {cur[WIDTH-2:0], ^(cur & TAPS)}.
- Edge detect: submit_d <= submit every cycle; edge = submit & ~submit_d.
- State IDLE:
  - On edge, capture sw_in and seq_num into g_r and s_r, then go to EVAL.
  - Without an edge, stay in IDLE.
- State EVAL (exactly 1 cycle):
  - expected <= next(s_r).
  - If s_r==0: illegal<=1, match<=0; score, streak and rounds are unchanged.
  - Else: illegal<=0, match <= (g_r==next(s_r)), rounds <= rounds+1.
    - If match: score++ and streak++, both saturating.
    - If miss: streak<=0.
  - Go to RESULT.
- Latency: if the edge is seen in cycle N, registered results and counters are visible from cycle N+2, with result_valid=1.
- State RESULT:
  - Hold outputs while submit==1.
  - When submit==0: go to DONE if rounds==MAX_ROUNDS, else go to IDLE.
  - result_valid drops on leaving RESULT.
  - match and illegal keep their values until the next EVAL.
- State DONE:
  - game_over=1; submit is ignored.
  - Leave DONE only via restart or reset.
- restart:
  - Acts in any state: clears score, streak, rounds, match, illegal and expected; state=IDLE; submit_d is updated normally.
  - restart asserted in the same cycle as an edge means the edge is discarded.
  - reset overrides restart.
- Reset mid-round (in EVAL or RESULT): the round is abandoned and all counters are 0 on the next cycle.
- Holding submit high produces exactly one round; the next round needs release then press.
- Inputs changing after the capture cycle do not affect the round in progress.
- Counters at 255 stay at 255.
- rounds never exceeds MAX_ROUNDS, because DONE blocks further rounds.
- Only next-state logic and a registered compare; no combinational path from inputs to outputs.

Test Plan:
1. Reset, seq_num=8'h01, sw_in=8'h02, one submit pulse.
   - expected=8'h02, match=1, score=1, streak=1, rounds=1.
   - result_valid rises 2 cycles after the edge.
2. seq_num=8'h80, sw_in=8'h01, then seq_num=8'hB8, sw_in=8'h71.
   - First round: expected=8'h01, match=1.
   - Second round: expected=8'h70, match=0, streak=0, score unchanged.
3. seq_num=8'h00, any sw_in, submit.
   - illegal=1, match=0, rounds, score and streak unchanged.
   - The next legal round clears illegal.
4. Hold submit high for 20 cycles with a correct guess → exactly one round counted, RESULT is held until release, then IDLE.
5. Play MAX_ROUNDS=8 correct rounds.
   - After the 8th release: game_over=1, score=8, and a further submit changes nothing.
   - restart → all counters 0, IDLE, game_over=0.
6. Assert reset during EVAL, and in another run assert restart together with a submit edge.
   - All outputs are 0 next cycle, and no round is counted from the coincident edge.

Source files
------------

// File: rtl/lfsr_guess_checker.sv
// LFSR guessing game checker: on each submit press, compares the player's guess with
// the true next LFSR state and tracks score, streak and round count.
module lfsr_guess_checker #(
    parameter int          WIDTH      = 8,
    parameter logic [WIDTH-1:0] TAPS  = 8'hB8,
    parameter int          MAX_ROUNDS = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] sw_in,
    input  logic [WIDTH-1:0] seq_num,
    input  logic             submit,
    input  logic             restart,
    output logic [WIDTH-1:0] expected,
    output logic             result_valid,
    output logic             match,
    output logic             illegal,
    output logic [7:0]       score,
    output logic [7:0]       streak,
    output logic [7:0]       rounds,
    output logic             game_over
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EVAL   = 2'd1,
        RESULT = 2'd2,
        DONE   = 2'd3
    } state_t;

    function automatic logic [WIDTH-1:0] lfsr_next(input logic [WIDTH-1:0] cur);
        lfsr_next = {cur[WIDTH-2:0], ^(cur & TAPS)};
    endfunction

    state_t           r_state,    w_state_nxt;
    logic             r_submit_d;
    logic [WIDTH-1:0] r_g,        w_g_nxt;
    logic [WIDTH-1:0] r_s,        w_s_nxt;
    logic [WIDTH-1:0] r_expected, w_expected_nxt;
    logic             r_match,    w_match_nxt;
    logic             r_illegal,  w_illegal_nxt;
    logic [7:0]       r_score,    w_score_nxt;
    logic [7:0]       r_streak,   w_streak_nxt;
    logic [7:0]       r_rounds,   w_rounds_nxt;
    logic             w_edge;
    logic [WIDTH-1:0] w_next_s;

    assign w_edge   = submit & ~r_submit_d;
    assign w_next_s = lfsr_next(r_s);

    // Next-state and next-value logic for the game FSM; restart overrides the FSM step.
    always_comb begin
        w_state_nxt    = r_state;
        w_g_nxt        = r_g;
        w_s_nxt        = r_s;
        w_expected_nxt = r_expected;
        w_match_nxt    = r_match;
        w_illegal_nxt  = r_illegal;
        w_score_nxt    = r_score;
        w_streak_nxt   = r_streak;
        w_rounds_nxt   = r_rounds;
        case (r_state)
            IDLE: begin
                if (w_edge) begin
                    w_g_nxt     = sw_in;
                    w_s_nxt     = seq_num;
                    w_state_nxt = EVAL;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            EVAL: begin
                w_expected_nxt = w_next_s;
                if (r_s == {WIDTH{1'b0}}) begin
                    w_illegal_nxt = 1'b1;
                    w_match_nxt   = 1'b0;
                end else begin
                    w_illegal_nxt = 1'b0;
                    w_match_nxt   = (r_g == w_next_s);
                    w_rounds_nxt  = r_rounds + 8'd1;
                    if (r_g == w_next_s) begin
                        w_score_nxt  = (r_score  == 8'hFF) ? r_score  : r_score  + 8'd1;
                        w_streak_nxt = (r_streak == 8'hFF) ? r_streak : r_streak + 8'd1;
                    end else begin
                        w_streak_nxt = 8'd0;
                    end
                end
                w_state_nxt = RESULT;
            end
            RESULT: begin
                if (!submit) begin
                    w_state_nxt = (r_rounds == 8'(MAX_ROUNDS)) ? DONE : IDLE;
                end else begin
                    w_state_nxt = RESULT;
                end
            end
            DONE: begin
                w_state_nxt = DONE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
        if (restart) begin
            w_state_nxt    = IDLE;
            w_expected_nxt = {WIDTH{1'b0}};
            w_match_nxt    = 1'b0;
            w_illegal_nxt  = 1'b0;
            w_score_nxt    = 8'd0;
            w_streak_nxt   = 8'd0;
            w_rounds_nxt   = 8'd0;
        end else begin
            w_state_nxt = w_state_nxt;
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_submit_d <= 1'b0;
            r_g        <= {WIDTH{1'b0}};
            r_s        <= {WIDTH{1'b0}};
            r_expected <= {WIDTH{1'b0}};
            r_match    <= 1'b0;
            r_illegal  <= 1'b0;
            r_score    <= 8'd0;
            r_streak   <= 8'd0;
            r_rounds   <= 8'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_submit_d <= submit;
            r_g        <= w_g_nxt;
            r_s        <= w_s_nxt;
            r_expected <= w_expected_nxt;
            r_match    <= w_match_nxt;
            r_illegal  <= w_illegal_nxt;
            r_score    <= w_score_nxt;
            r_streak   <= w_streak_nxt;
            r_rounds   <= w_rounds_nxt;
        end
    end

    assign expected     = r_expected;
    assign match        = r_match;
    assign illegal      = r_illegal;
    assign score        = r_score;
    assign streak       = r_streak;
    assign rounds       = r_rounds;
    assign result_valid = (r_state == RESULT);
    assign game_over    = (r_state == DONE);

endmodule

// File: tb/tb_lfsr_guess_checker.sv
// Directed testbench for lfsr_guess_checker with hand-computed expectations.
module tb_lfsr_guess_checker;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] sw_in;
    logic [7:0] seq_num;
    logic       submit;
    logic       restart;
    logic [7:0] expected;
    logic       result_valid;
    logic       match;
    logic       illegal;
    logic [7:0] score;
    logic [7:0] streak;
    logic [7:0] rounds;
    logic       game_over;

    int n_checks = 0;
    int n_errors = 0;

    lfsr_guess_checker #(.WIDTH(8), .TAPS(8'hB8), .MAX_ROUNDS(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .sw_in        (sw_in),
        .seq_num      (seq_num),
        .submit       (submit),
        .restart      (restart),
        .expected     (expected),
        .result_valid (result_valid),
        .match        (match),
        .illegal      (illegal),
        .score        (score),
        .streak       (streak),
        .rounds       (rounds),
        .game_over    (game_over)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Press submit and advance to the first RESULT cycle; submit stays high.
    task automatic press(input logic [7:0] g, input logic [7:0] s);
        sw_in   = g;
        seq_num = s;
        submit  = 1'b1;
        tick();
        sw_in   = 8'hEE;
        seq_num = 8'h33;
        tick();
    endtask

    task automatic release_btn();
        submit = 1'b0;
        tick();
    endtask

    task automatic chk_counts(input string tag, input logic [7:0] sc, input logic [7:0] st,
                              input logic [7:0] rd);
        chk({tag, "_score"},  {24'd0, score},  {24'd0, sc});
        chk({tag, "_streak"}, {24'd0, streak}, {24'd0, st});
        chk({tag, "_rounds"}, {24'd0, rounds}, {24'd0, rd});
    endtask

    logic [7:0] seq_tab [8];
    logic [7:0] gue_tab [8];

    initial begin
        seq_tab = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
        gue_tab = '{8'h02, 8'h04, 8'h08, 8'h11, 8'h21, 8'h41, 8'h80, 8'h01};
        reset   = 1'b1;
        restart = 1'b0;
        submit  = 1'b0;
        sw_in   = 8'h00;
        seq_num = 8'h00;
        tick();
        tick();
        reset = 1'b0;
        chk("rst_expected", {24'd0, expected}, 32'h0);
        chk("rst_valid", {31'd0, result_valid}, 32'd0);
        chk("rst_match", {31'd0, match}, 32'd0);
        chk("rst_illegal", {31'd0, illegal}, 32'd0);
        chk("rst_game_over", {31'd0, game_over}, 32'd0);
        chk_counts("rst", 8'd0, 8'd0, 8'd0);

        // Test 1: latency and first correct round.
        sw_in   = 8'h02;
        seq_num = 8'h01;
        submit  = 1'b1;
        tick();
        chk("t1_valid_n1", {31'd0, result_valid}, 32'd0);
        chk("t1_rounds_n1", {24'd0, rounds}, 32'd0);
        tick();
        chk("t1_valid_n2", {31'd0, result_valid}, 32'd1);
        chk("t1_expected", {24'd0, expected}, 32'h02);
        chk("t1_match", {31'd0, match}, 32'd1);
        chk_counts("t1", 8'd1, 8'd1, 8'd1);
        release_btn();
        chk("t1_valid_rel", {31'd0, result_valid}, 32'd0);
        chk("t1_match_kept", {31'd0, match}, 32'd1);

        // Test 2: feedback bit set, then a miss.
        press(8'h01, 8'h80);
        chk("t2a_expected", {24'd0, expected}, 32'h01);
        chk("t2a_match", {31'd0, match}, 32'd1);
        chk_counts("t2a", 8'd2, 8'd2, 8'd2);
        release_btn();
        press(8'h71, 8'hB8);
        chk("t2b_expected", {24'd0, expected}, 32'h70);
        chk("t2b_match", {31'd0, match}, 32'd0);
        chk_counts("t2b", 8'd2, 8'd0, 8'd3);
        release_btn();

        // Test 3: illegal zero seed, then a legal round clears it.
        press(8'h55, 8'h00);
        chk("t3_illegal", {31'd0, illegal}, 32'd1);
        chk("t3_match", {31'd0, match}, 32'd0);
        chk("t3_valid", {31'd0, result_valid}, 32'd1);
        chk_counts("t3", 8'd2, 8'd0, 8'd3);
        release_btn();
        press(8'h02, 8'h01);
        chk("t3b_illegal", {31'd0, illegal}, 32'd0);
        chk("t3b_match", {31'd0, match}, 32'd1);
        chk_counts("t3b", 8'd3, 8'd1, 8'd4);
        release_btn();

        // Test 4: held submit gives exactly one round.
        press(8'h04, 8'h02);
        for (int i = 0; i < 18; i++) tick();
        chk("t4_valid_held", {31'd0, result_valid}, 32'd1);
        chk_counts("t4", 8'd4, 8'd2, 8'd5);
        release_btn();
        chk("t4_valid_rel", {31'd0, result_valid}, 32'd0);
        chk("t4_game_over", {31'd0, game_over}, 32'd0);
        tick();
        tick();
        chk("t4_rounds_after", {24'd0, rounds}, 32'd5);

        // Test 5: full game of eight correct rounds.
        restart = 1'b1;
        tick();
        restart = 1'b0;
        chk_counts("t5_rs", 8'd0, 8'd0, 8'd0);
        for (int i = 0; i < 8; i++) begin
            press(gue_tab[i], seq_tab[i]);
            chk($sformatf("t5_exp%0d", i), {24'd0, expected}, {24'd0, gue_tab[i]});
            chk($sformatf("t5_match%0d", i), {31'd0, match}, 32'd1);
            release_btn();
        end
        chk("t5_game_over", {31'd0, game_over}, 32'd1);
        chk_counts("t5_done", 8'd8, 8'd8, 8'd8);
        press(8'h02, 8'h01);
        tick();
        chk("t5_done_valid", {31'd0, result_valid}, 32'd0);
        chk("t5_done_go", {31'd0, game_over}, 32'd1);
        chk_counts("t5_ignored", 8'd8, 8'd8, 8'd8);
        release_btn();
        restart = 1'b1;
        tick();
        restart = 1'b0;
        chk("t5_rs_go", {31'd0, game_over}, 32'd0);
        chk("t5_rs_match", {31'd0, match}, 32'd0);
        chk("t5_rs_expected", {24'd0, expected}, 32'h0);
        chk_counts("t5_rs2", 8'd0, 8'd0, 8'd0);
        press(8'h02, 8'h01);
        chk("t5_idle_again", {31'd0, result_valid}, 32'd1);
        release_btn();

        // Test 6a: reset while in EVAL abandons the round.
        chk_counts("t6a_pre", 8'd1, 8'd1, 8'd1);
        sw_in   = 8'h04;
        seq_num = 8'h02;
        submit  = 1'b1;
        tick();
        reset  = 1'b1;
        submit = 1'b0;
        tick();
        reset = 1'b0;
        chk("t6a_valid", {31'd0, result_valid}, 32'd0);
        chk("t6a_match", {31'd0, match}, 32'd0);
        chk("t6a_expected", {24'd0, expected}, 32'h0);
        chk_counts("t6a", 8'd0, 8'd0, 8'd0);
        tick();
        tick();
        chk("t6a_later_rounds", {24'd0, rounds}, 32'd0);

        // Test 6b: restart coincident with an edge discards the edge.
        press(8'h02, 8'h01);
        release_btn();
        chk_counts("t6b_pre", 8'd1, 8'd1, 8'd1);
        sw_in   = 8'h02;
        seq_num = 8'h01;
        submit  = 1'b1;
        restart = 1'b1;
        tick();
        restart = 1'b0;
        chk("t6b_valid", {31'd0, result_valid}, 32'd0);
        chk("t6b_match", {31'd0, match}, 32'd0);
        chk_counts("t6b", 8'd0, 8'd0, 8'd0);
        tick();
        tick();
        chk("t6b_valid_later", {31'd0, result_valid}, 32'd0);
        chk("t6b_rounds_later", {24'd0, rounds}, 32'd0);
        release_btn();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
